// File: rtl/mdu_if.sv
// Request/response handshake bundle between the execution stage and the
// iterative multiply/divide unit.
interface mdu_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, op, src1, src2, flush, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, src1, src2, flush, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/mdu.sv
// Iterative RV32M multiply/divide engine: radix-2 shift-add multiply and
// radix-2 restoring divide, one bit per cycle, valid/ready on both sides.
module mdu #(
    parameter int unsigned XLEN = 32
) (
    input  logic clk,
    input  logic rst,
    mdu_if.slave bus
);
    localparam int unsigned CNT_W     = $clog2(XLEN + 1);
    localparam logic [2:0]  OP_MUL    = 3'b000;
    localparam logic [2:0]  OP_MULH   = 3'b001;
    localparam logic [2:0]  OP_MULHSU = 3'b010;
    localparam logic [2:0]  OP_DIV    = 3'b100;
    localparam logic [2:0]  OP_REM    = 3'b110;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  acc_q, acc_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    logic [XLEN-1:0]  opb_q, opb_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [2:0]       op_q, op_d;
    logic             neg_q, neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             special_q, special_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;

    // Request decode: operand magnitudes, result signs and short-circuit cases
    logic            accept, src1_signed, src2_signed, src1_neg, src2_neg;
    logic            div0, ovf;
    logic [XLEN-1:0] mag1, mag2, special_res;

    assign accept      = bus.in_valid & in_ready_q & ~bus.flush;
    assign src1_signed = (bus.op == OP_MULH) | (bus.op == OP_MULHSU) |
                         (bus.op == OP_DIV)  | (bus.op == OP_REM);
    assign src2_signed = (bus.op == OP_MULH) | (bus.op == OP_DIV) | (bus.op == OP_REM);
    assign src1_neg    = src1_signed & bus.src1[XLEN-1];
    assign src2_neg    = src2_signed & bus.src2[XLEN-1];
    assign mag1        = src1_neg ? -bus.src1 : bus.src1;
    assign mag2        = src2_neg ? -bus.src2 : bus.src2;
    assign div0        = bus.op[2] & (bus.src2 == '0);
    assign ovf         = bus.op[2] & ~bus.op[0] & (bus.src2 == '1) &
                         (bus.src1 == {1'b1, {(XLEN-1){1'b0}}});
    assign special_res = div0 ? (bus.op[1] ? bus.src1 : '1)
                              : (bus.op[1] ? '0 : bus.src1);

    // Multiply step: {acc, lo} holds the partial product, lo shifts the multiplier out
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_prod, mul_fix;

    assign mul_sum  = {1'b0, acc_q} + {1'b0, {XLEN{lo_q[0]}} & opb_q};
    assign mul_prod = {mul_sum, lo_q[XLEN-1:1]};
    assign mul_fix  = neg_q ? -mul_prod : mul_prod;

    // Divide step: acc is the partial remainder, lo shifts dividend out and quotient in
    logic [XLEN:0]   div_shift;
    logic            div_borrow;
    logic [XLEN-1:0] div_rem, quo_fin, quo_fix, rem_fix;
    logic            last;

    assign div_shift  = {acc_q, lo_q[XLEN-1]};
    assign div_borrow = div_shift < {1'b0, opb_q};
    assign div_rem    = div_borrow ? div_shift[XLEN-1:0] : div_shift[XLEN-1:0] - opb_q;
    assign quo_fin    = {lo_q[XLEN-2:0], ~div_borrow};
    assign quo_fix    = neg_q ? -quo_fin : quo_fin;
    assign rem_fix    = rem_neg_q ? -div_rem : div_rem;
    assign last       = (cnt_q == CNT_W'(XLEN - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        lo_d      = lo_q;
        opb_d     = opb_q;
        result_d  = result_q;
        op_d      = op_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        special_d = special_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d      = bus.op;
                    cnt_d     = '0;
                    acc_d     = '0;
                    neg_d     = src1_neg ^ src2_neg;
                    rem_neg_d = src1_neg;
                    special_d = div0 | ovf;
                    if (bus.op[2]) begin
                        lo_d  = mag1;
                        opb_d = mag2;
                    end else begin
                        lo_d  = mag2;
                        opb_d = mag1;
                    end
                    // Special cases park their answer now and leave DIV after one cycle
                    if (div0 | ovf) begin
                        result_d = special_res;
                        state_d  = DIV;
                    end else begin
                        state_d  = bus.op[2] ? DIV : MUL;
                    end
                end
            end
            MUL: begin
                acc_d = mul_sum[XLEN:1];
                lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (last) begin
                    result_d = (op_q == OP_MUL) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];
                    state_d  = DONE;
                end
            end
            DIV: begin
                if (special_q) begin
                    state_d = DONE;
                end else begin
                    acc_d = div_rem;
                    lo_d  = quo_fin;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last) begin
                        result_d = op_q[1] ? rem_fix : quo_fix;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (bus.flush) state_d = IDLE;

        out_valid_d = (state_d == DONE);
        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            lo_q        <= '0;
            opb_q       <= '0;
            result_q    <= '0;
            op_q        <= '0;
            neg_q       <= 1'b0;
            rem_neg_q   <= 1'b0;
            special_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            lo_q        <= lo_d;
            opb_q       <= opb_d;
            result_q    <= result_d;
            op_q        <= op_d;
            neg_q       <= neg_d;
            rem_neg_q   <= rem_neg_d;
            special_q   <= special_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed RV32M vectors, randomized ops against
// a 64-bit arithmetic reference, backpressure, flush and asynchronous reset.
module tb_mdu;
    localparam int unsigned XLEN = 32;
    localparam logic [31:0] MIN  = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    mdu_if #(.XLEN(XLEN)) bus ();
    mdu #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Reference results from plain 64-bit arithmetic and the RV32M corner rules
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0]        ua, ub, p;
        sa = 64'($signed(a));
        sb = 64'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * $signed(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == MIN && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == MIN && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 32'd0 || (!op[0] && a == MIN && b == 32'hFFFF_FFFF))) return 1;
        return XLEN;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return MIN;
            default: return $urandom;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request and hold it across exactly one accepting edge
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < 100 && bus.in_ready !== 1'b1; i++) step();
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.src1     = a;
        bus.src2     = b;
        step();
        bus.in_valid = 1'b0;
        bus.op       = 3'($urandom);
        bus.src1     = $urandom;
        bus.src2     = $urandom;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            step();
            lat++;
        end
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_checks++; if (bus.result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", bus.result); end
    endtask

    task automatic test_mul();
        logic [2:0]  t_op [4];
        logic [31:0] t_a [4], t_b [4], t_r [4];
        int lat;
        t_op = '{3'd0, 3'd1, 3'd3, 3'd2};
        t_a  = '{32'h7, 32'h7, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        t_b  = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h2};
        t_r  = '{32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        for (int i = 0; i < 4; i++) begin
            issue(t_op[i], t_a[i], t_b[i]);
            wait_done(lat);
            n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL mul_latency[%0d]: got %0d expected 32", i, lat); end
            n_checks++; if (bus.result !== t_r[i]) begin n_fail++; $display("FAIL mul_result[%0d]: got %h expected %h", i, bus.result, t_r[i]); end
            take();
        end
    endtask

    task automatic test_div();
        logic [2:0]  t_op [4];
        logic [31:0] t_a [4], t_b [4], t_r [4];
        int lat;
        t_op = '{3'd4, 3'd6, 3'd5, 3'd7};
        t_a  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        t_b  = '{32'd2, 32'd2, 32'd7, 32'd7};
        t_r  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        for (int i = 0; i < 4; i++) begin
            issue(t_op[i], t_a[i], t_b[i]);
            wait_done(lat);
            n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL div_latency[%0d]: got %0d expected 32", i, lat); end
            n_checks++; if (bus.result !== t_r[i]) begin n_fail++; $display("FAIL div_result[%0d]: got %h expected %h", i, bus.result, t_r[i]); end
            take();
        end
    endtask

    task automatic test_special();
        logic [2:0]  t_op [4];
        logic [31:0] t_a [4], t_b [4], t_r [4];
        int lat;
        t_op = '{3'd5, 3'd6, 3'd4, 3'd6};
        t_a  = '{32'd5, 32'd5, MIN, MIN};
        t_b  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        t_r  = '{32'hFFFF_FFFF, 32'd5, MIN, 32'd0};
        for (int i = 0; i < 4; i++) begin
            issue(t_op[i], t_a[i], t_b[i]);
            wait_done(lat);
            n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL special_latency[%0d]: got %0d expected 1", i, lat); end
            n_checks++; if (bus.result !== t_r[i]) begin n_fail++; $display("FAIL special_result[%0d]: got %h expected %h", i, bus.result, t_r[i]); end
            take();
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b, exp;
        int lat;
        for (int i = 0; i < 300; i++) begin
            op  = 3'($urandom_range(0, 7));
            a   = pick_operand();
            b   = pick_operand();
            exp = ref_model(op, a, b);
            issue(op, a, b);
            wait_done(lat);
            n_checks++; if (lat !== exp_latency(op, a, b)) begin n_fail++; $display("FAIL rand_latency[%0d] op=%0d a=%h b=%h: got %0d expected %0d", i, op, a, b, lat, exp_latency(op, a, b)); end
            repeat ($urandom_range(0, 2)) step();
            n_checks++; if (bus.result !== exp) begin n_fail++; $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, bus.result, exp); end
            take();
            repeat ($urandom_range(0, 1)) step();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b, exp;
        int lat;
        a   = $urandom;
        b   = $urandom;
        exp = ref_model(3'd1, a, b);
        issue(3'd1, a, b);
        wait_done(lat);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.op       = 3'd5;
            bus.src1     = $urandom;
            bus.src2     = $urandom;
            step();
            n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid[%0d]: got %b expected 1", i, bus.out_valid); end
            n_checks++; if (bus.result !== exp) begin n_fail++; $display("FAIL bp_result[%0d]: got %h expected %h", i, bus.result, exp); end
            n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, bus.in_ready); end
        end
        bus.in_valid = 1'b0;
        take();
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after: got %b expected 1", bus.in_ready); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL bp_busy_after: got %b expected 0", bus.busy); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_after: got %b expected 0", bus.out_valid); end
        test_back_to_back();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, exp;
        int lat;
        a   = $urandom;
        b   = $urandom_range(1, 1000);
        exp = ref_model(3'd7, a, b);
        issue(3'd7, a, b);
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: busy got %b expected 1", bus.busy); end
        wait_done(lat);
        n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 32", lat); end
        n_checks++; if (bus.result !== exp) begin n_fail++; $display("FAIL b2b_result: got %h expected %h", bus.result, exp); end
        take();
    endtask

    task automatic test_flush();
        logic [31:0] a, b, exp;
        logic        seen;
        int lat;
        issue(3'd4, $urandom, ($urandom | 32'd1) & 32'h7FFF_FFFF);
        repeat (4) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b expected 0", bus.busy); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 1", bus.in_ready); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid === 1'b1) seen = 1'b1;
            step();
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_no_result: out_valid rose got %b expected 0", seen); end

        // flush beats a simultaneous request
        bus.in_valid = 1'b1;
        bus.op       = 3'd0;
        bus.flush    = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_vs_accept: busy got %b expected 0", bus.busy); end

        // flush beats a simultaneous output handshake
        issue(3'd5, 32'd9, 32'd0);
        wait_done(lat);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_vs_handshake: valid/busy got %b%b expected 00", bus.out_valid, bus.busy); end

        a   = $urandom;
        b   = $urandom;
        exp = ref_model(3'd2, a, b);
        issue(3'd2, a, b);
        wait_done(lat);
        n_checks++; if (bus.result !== exp || lat !== 32) begin n_fail++; $display("FAIL flush_next_op: got %h lat %0d expected %h lat 32", bus.result, lat, exp); end
        take();
    endtask

    task automatic test_async_reset();
        logic [31:0] a, b, exp;
        int lat;
        issue(3'd6, $urandom, 32'd13);
        repeat (10) step();
        #2 rst = 1'b0;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_out_valid: got %b expected 0", bus.out_valid); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b expected 0", bus.busy); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_in_ready: got %b expected 1", bus.in_ready); end
        n_checks++; if (bus.result !== 32'd0) begin n_fail++; $display("FAIL arst_result: got %h expected 0", bus.result); end
        @(posedge clk);
        #3 rst = 1'b1;
        a   = $urandom;
        b   = $urandom;
        exp = ref_model(3'd4, a, b);
        issue(3'd4, a, b);
        wait_done(lat);
        n_checks++; if (bus.result !== exp || lat !== exp_latency(3'd4, a, b)) begin n_fail++; $display("FAIL arst_next_op: got %h lat %0d expected %h", bus.result, lat, exp); end
        take();
    endtask

    initial begin
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = 3'd0;
        bus.src1      = 32'd0;
        bus.src2      = 32'd0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b1;
        step();
        test_mul();
        test_div();
        test_special();
        test_random();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
